// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: forms the effective address of a memory-reference instruction and performs one operand read or store
// Configuration macro: AUTO_INDEX_EN (page-zero auto-index pointers AUTO_LO..AUTO_HI pre-increment on indirection)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, write             request pulse (sampled in IDLE), 1 = store / 0 = read
//   instr, pc, wdata         instruction word, its address, store data (latched with start)
//   mem_rdata                combinational memory read data
//   mem_addr, mem_rden,
//   mem_wren, mem_wdata      memory address/control/write data
//   busy, done               in-flight flag, one-cycle completion pulse
//   eff_addr, operand        resolved EA and read data, held until the next start
module operand_fetch_unit #(
    parameter int AW      = 12,
    parameter int DW      = 12,
    parameter int AUTO_LO = 8,
    parameter int AUTO_HI = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          write,
    input  logic [DW-1:0] instr,
    input  logic [AW-1:0] pc,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rden,
    output logic          mem_wren,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] eff_addr,
    output logic [DW-1:0] operand
);
`ifdef AUTO_INDEX_EN
    typedef enum logic [2:0] {IDLE, INDIR, ACCESS, DONE, AINC} state_t;
    localparam bit AUTO_EN = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, INDIR, ACCESS, DONE} state_t;
    localparam bit AUTO_EN = 1'b0;
`endif
    state_t state, ns;
    logic          wr_q;
    logic [DW-1:0] instr_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] ea;
    logic [AW-1:0] da;
    logic          auto_hit;
    logic          unused_ok;
    // Page bit selects the instruction's own page; offset never carries into the page bits.
    function automatic logic [AW-1:0] da_of(input logic [7:0] i, input logic [AW-1:0] p);
        return i[7] ? {p[AW-1:7], i[6:0]} : {{(AW-7){1'b0}}, i[6:0]};
    endfunction
    assign da        = da_of(instr_q[7:0], pc_q);
    assign auto_hit  = AUTO_EN && !instr_q[7] && (instr_q[6:0] >= AUTO_LO[6:0]) && (instr_q[6:0] <= AUTO_HI[6:0]);
    assign unused_ok = ^{instr_q[DW-1:8], pc_q[6:0]};
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = state == DONE;
    assign eff_addr  = ea;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= ns;
    end
    always_comb begin
        ns        = state;
        mem_addr  = '0;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE:   ns = start ? (instr[8] ? INDIR : ACCESS) : IDLE;
            INDIR: begin
                mem_addr = da;
                mem_rden = 1'b1;
`ifdef AUTO_INDEX_EN
                ns = auto_hit ? AINC : ACCESS;
`else
                ns = ACCESS;
`endif
            end
            ACCESS: begin
                mem_addr  = ea;
                mem_rden  = !wr_q;
                mem_wren  = wr_q;
                mem_wdata = wr_q ? wdata_q : '0;
                ns        = DONE;
            end
`ifdef AUTO_INDEX_EN
            AINC: begin
                mem_addr  = da;
                mem_wren  = 1'b1;
                mem_wdata = ea;
                ns        = ACCESS;
            end
`endif
            default: ns = IDLE;
        endcase
        // A reset arriving mid-access must not let a store reach memory.
        if (rst) begin
            mem_rden = 1'b0;
            mem_wren = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            wdata_q <= '0;
            ea      <= '0;
            operand <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    wr_q    <= write;
                    instr_q <= instr;
                    pc_q    <= pc;
                    wdata_q <= wdata;
                    ea      <= da_of(instr[7:0], pc);
                end
                // With auto-index the incremented pointer doubles as the final EA.
                INDIR:  ea <= mem_rdata + DW'(auto_hit);
                ACCESS: if (!wr_q) operand <= mem_rdata;
                default: ;
            endcase
        end
    end
endmodule
